// File: rtl/fetch_stall_ctrl_pkg.sv
// Shared pipeline constants for the fetch/stall controller: control-bundle layout,
// reset/nop values and the two legal hazard-unit request encodings.
package fetch_stall_ctrl_pkg;

   localparam int CTRL_BUNDLE_W = 9;

   localparam int CTRL_REGDST   = 8;
   localparam int CTRL_ALUSRC   = 7;
   localparam int CTRL_MEMTOREG = 6;
   localparam int CTRL_REGWRITE = 5;
   localparam int CTRL_MEMREAD  = 4;
   localparam int CTRL_MEMWRITE = 3;
   localparam int CTRL_BRANCH   = 2;
   localparam int CTRL_ALUOP_HI = 1;
   localparam int CTRL_ALUOP_LO = 0;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Request encoding is {pc_write, if_id_write, mux_sel}
   localparam logic [2:0] STALL_RUN  = 3'b110;
   localparam logic [2:0] STALL_HOLD = 3'b001;

   function automatic logic isLegalStall(input logic [2:0] req);
      return (req == STALL_RUN) || (req == STALL_HOLD);
   endfunction

endpackage

// File: rtl/fetch_stall_ctrl_if.sv
// Bundle of hazard-unit requests, fetch/decode data and controller outputs.
// master = hazard unit / pipeline side, slave = fetch_stall_ctrl.
interface fetch_stall_ctrl_if #(
   parameter int PC_W    = 32,
   parameter int INSTR_W = 32,
   parameter int CTRL_W  = 9,
   parameter int CNT_W   = 16
);

   logic               pc_write;
   logic               if_id_write;
   logic               mux_sel;
   logic               branch_taken;
   logic [PC_W-1:0]    branch_target;
   logic [INSTR_W-1:0] instr_in;
   logic [CTRL_W-1:0]  id_ctrl_in;

   logic [PC_W-1:0]    pc;
   logic [INSTR_W-1:0] if_id_instr;
   logic [PC_W-1:0]    if_id_pc4;
   logic               if_id_valid;
   logic [CTRL_W-1:0]  id_ex_ctrl;
   logic [CNT_W-1:0]   stall_cnt;
   logic [CNT_W-1:0]   flush_cnt;
   logic               protocol_err;

   modport master (
      output pc_write, if_id_write, mux_sel, branch_taken, branch_target, instr_in, id_ctrl_in,
      input  pc, if_id_instr, if_id_pc4, if_id_valid, id_ex_ctrl, stall_cnt, flush_cnt, protocol_err
   );

   modport slave (
      input  pc_write, if_id_write, mux_sel, branch_taken, branch_target, instr_in, id_ctrl_in,
      output pc, if_id_instr, if_id_pc4, if_id_valid, id_ex_ctrl, stall_cnt, flush_cnt, protocol_err
   );

endinterface

// File: rtl/fetch_stall_ctrl_sat_counter.sv
// Saturating up-counter: increments on i_inc and sticks at all-ones.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_inc,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] r_count;
   logic             w_atMax;

   assign w_atMax = &r_count;
   assign o_count = r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_inc && !w_atMax) begin
         r_count <= r_count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/fetch_stall_ctrl.sv
// PC, IF/ID and ID/EX-control registers driven by hazard-unit stall requests and
// the ID-stage branch decision, with stall/flush counters and a protocol flag.
module fetch_stall_ctrl
   import fetch_stall_ctrl_pkg::*;
#(
   parameter int              PC_W     = 32,
   parameter int              INSTR_W  = 32,
   parameter int              CTRL_W   = CTRL_BUNDLE_W,
   parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEFAULT_RESET_PC),
   parameter int              CNT_W    = 16
) (
   input logic               clk,
   input logic               rst_n,
   fetch_stall_ctrl_if.slave bus
);

   logic [PC_W-1:0]    r_pc;
   logic [INSTR_W-1:0] r_ifIdInstr;
   logic [PC_W-1:0]    r_ifIdPc4;
   logic               r_ifIdValid;
   logic [CTRL_W-1:0]  r_idExCtrl;
   logic               r_protocolErr;

   logic [PC_W-1:0]    w_pcPlus4;
   logic [2:0]         w_stallReq;
   logic               w_branchAccept;
   logic [CNT_W-1:0]   w_stallCnt;
   logic [CNT_W-1:0]   w_flushCnt;

   assign w_pcPlus4      = r_pc + PC_W'(4);
   assign w_stallReq     = {bus.pc_write, bus.if_id_write, bus.mux_sel};
   // A branch only counts when the PC may move; while stalled its operands are stale
   assign w_branchAccept = bus.pc_write & bus.branch_taken;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc <= RESET_PC;
      end else if (bus.pc_write) begin
         r_pc <= bus.branch_taken ? bus.branch_target : w_pcPlus4;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ifIdInstr <= INSTR_W'(NOP_INSTR);
         r_ifIdPc4   <= '0;
         r_ifIdValid <= 1'b0;
      end else if (bus.if_id_write) begin
         if (bus.branch_taken) begin
            r_ifIdInstr <= INSTR_W'(NOP_INSTR);
            r_ifIdPc4   <= '0;
            r_ifIdValid <= 1'b0;
         end else begin
            r_ifIdInstr <= bus.instr_in;
            r_ifIdPc4   <= w_pcPlus4;
            r_ifIdValid <= 1'b1;
         end
      end
   end

   // ID/EX control is never held: a stall shows up as exactly one zeroed bundle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idExCtrl <= '0;
      end else begin
         r_idExCtrl <= bus.mux_sel ? '0 : bus.id_ctrl_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_protocolErr <= 1'b0;
      end else if (!isLegalStall(w_stallReq)) begin
         r_protocolErr <= 1'b1;
      end
   end

   sat_counter #(.WIDTH(CNT_W)) u_stallCnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (bus.mux_sel),
      .o_count (w_stallCnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_flushCnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (w_branchAccept),
      .o_count (w_flushCnt)
   );

   assign bus.pc           = r_pc;
   assign bus.if_id_instr  = r_ifIdInstr;
   assign bus.if_id_pc4    = r_ifIdPc4;
   assign bus.if_id_valid  = r_ifIdValid;
   assign bus.id_ex_ctrl   = r_idExCtrl;
   assign bus.stall_cnt    = w_stallCnt;
   assign bus.flush_cnt    = w_flushCnt;
   assign bus.protocol_err = r_protocolErr;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Bench for fetch_stall_ctrl: table of request vectors with expected register state,
// routed through an expectation queue, plus wrap/saturation/illegal/reset sequences.
module tb_fetch_stall_ctrl;
   import fetch_stall_ctrl_pkg::*;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic [8:0]  ctrl;
      logic [3:0]  stallCnt;
      logic [3:0]  flushCnt;
      logic        err;
   } exp_t;

   typedef struct packed {
      logic [2:0]  req;
      logic        bt;
      logic [31:0] tgt;
      logic [31:0] instr;
      logic [8:0]  ctrl;
      exp_t        exp;
   } vec_t;

   logic clk;
   logic rst_n;
   int   testsRun;
   int   testsFailed;
   exp_t expQ[$];
   vec_t vecs[9];

   logic [8:0] ctrlLw, ctrlR, ctrlBeq, ctrlSw;

   fetch_stall_ctrl_if #(.PC_W(32), .INSTR_W(32), .CTRL_W(9), .CNT_W(4)) bus ();

   fetch_stall_ctrl #(.PC_W(32), .INSTR_W(32), .CTRL_W(9), .RESET_PC(32'h0), .CNT_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mkVec(input logic [2:0] req, input logic bt, input logic [31:0] tgt,
                                  input logic [31:0] instr, input logic [8:0] ctrl,
                                  input logic [31:0] ePc, input logic [31:0] eInstr,
                                  input logic [31:0] ePc4, input logic eValid, input logic [8:0] eCtrl,
                                  input int eStall, input int eFlush, input logic eErr);
      vec_t v;
      v.req = req; v.bt = bt; v.tgt = tgt; v.instr = instr; v.ctrl = ctrl;
      v.exp.pc = ePc; v.exp.instr = eInstr; v.exp.pc4 = ePc4; v.exp.valid = eValid;
      v.exp.ctrl = eCtrl; v.exp.stallCnt = 4'(eStall); v.exp.flushCnt = 4'(eFlush); v.exp.err = eErr;
      return v;
   endfunction

   task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput();
      exp_t e;
      if (expQ.size() == 0) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL scoreboard: output cycle with no expectation queued");
      end else begin
         e = expQ.pop_front();
         checkField("pc",           bus.pc,                  e.pc);
         checkField("if_id_instr",  bus.if_id_instr,         e.instr);
         checkField("if_id_pc4",    bus.if_id_pc4,           e.pc4);
         checkField("if_id_valid",  32'(bus.if_id_valid),    32'(e.valid));
         checkField("id_ex_ctrl",   32'(bus.id_ex_ctrl),     32'(e.ctrl));
         checkField("stall_cnt",    32'(bus.stall_cnt),      32'(e.stallCnt));
         checkField("flush_cnt",    32'(bus.flush_cnt),      32'(e.flushCnt));
         checkField("protocol_err", 32'(bus.protocol_err),   32'(e.err));
      end
   endtask

   task automatic checkReset(input string tag);
      checkField({tag, " pc"},           bus.pc,                32'h0);
      checkField({tag, " if_id_instr"},  bus.if_id_instr,       NOP_INSTR);
      checkField({tag, " if_id_pc4"},    bus.if_id_pc4,         32'h0);
      checkField({tag, " if_id_valid"},  32'(bus.if_id_valid),  32'h0);
      checkField({tag, " id_ex_ctrl"},   32'(bus.id_ex_ctrl),   32'h0);
      checkField({tag, " stall_cnt"},    32'(bus.stall_cnt),    32'h0);
      checkField({tag, " flush_cnt"},    32'(bus.flush_cnt),    32'h0);
      checkField({tag, " protocol_err"}, 32'(bus.protocol_err), 32'h0);
   endtask

   task automatic driveInputs(input vec_t v);
      bus.pc_write      = v.req[2];
      bus.if_id_write   = v.req[1];
      bus.mux_sel       = v.req[0];
      bus.branch_taken  = v.bt;
      bus.branch_target = v.tgt;
      bus.instr_in      = v.instr;
      bus.id_ctrl_in    = v.ctrl;
   endtask

   task automatic applyStimulus(input vec_t v);
      driveInputs(v);
      expQ.push_back(v.exp);
      @(posedge clk);
      @(negedge clk);
      checkOutput();
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      ctrlLw  = (9'd1 << CTRL_ALUSRC) | (9'd1 << CTRL_MEMTOREG) | (9'd1 << CTRL_REGWRITE) | (9'd1 << CTRL_MEMREAD);
      ctrlR   = (9'd1 << CTRL_REGDST) | (9'd1 << CTRL_REGWRITE) | (9'd1 << CTRL_ALUOP_HI);
      ctrlBeq = (9'd1 << CTRL_BRANCH) | (9'd1 << CTRL_ALUOP_LO);
      ctrlSw  = (9'd1 << CTRL_ALUSRC) | (9'd1 << CTRL_MEMWRITE);

      //                req      bt  tgt        instr_in      ctrl_in   pc           if_id_instr   pc4          v  id_ex    sc fc err
      vecs[0] = mkVec(STALL_RUN,  0, 32'h0,     32'h8C080004, ctrlLw,   32'h4,       32'h8C080004, 32'h4,       1, ctrlLw,  0, 0, 0);
      vecs[1] = mkVec(STALL_RUN,  0, 32'h0,     32'h01094020, ctrlR,    32'h8,       32'h01094020, 32'h8,       1, ctrlR,   0, 0, 0);
      vecs[2] = mkVec(STALL_HOLD, 0, 32'h0,     32'h00000000, ctrlR,    32'h8,       32'h01094020, 32'h8,       1, 9'h0,    1, 0, 0);
      vecs[3] = mkVec(STALL_RUN,  0, 32'h0,     32'h00000000, ctrlR,    32'hC,       32'h00000000, 32'hC,       1, ctrlR,   1, 0, 0);
      vecs[4] = mkVec(STALL_RUN,  0, 32'h0,     32'h1000000C, 9'h0,     32'h10,      32'h1000000C, 32'h10,      1, 9'h0,    1, 0, 0);
      vecs[5] = mkVec(STALL_RUN,  1, 32'h40,    32'hDEADBEEF, ctrlBeq,  32'h40,      32'h00000000, 32'h0,       0, ctrlBeq, 1, 1, 0);
      vecs[6] = mkVec(STALL_RUN,  0, 32'h0,     32'h8C090008, 9'h0,     32'h44,      32'h8C090008, 32'h44,      1, 9'h0,    1, 1, 0);
      vecs[7] = mkVec(STALL_HOLD, 1, 32'h80,    32'h01294820, ctrlLw,   32'h44,      32'h8C090008, 32'h44,      1, 9'h0,    2, 1, 0);
      vecs[8] = mkVec(STALL_RUN,  0, 32'h0,     32'h01294820, ctrlLw,   32'h48,      32'h01294820, 32'h48,      1, ctrlLw,  2, 1, 0);

      rst_n = 1'b0;
      driveInputs(mkVec(3'b000, 0, 32'h0, 32'h0, 9'h0, 32'h0, 32'h0, 32'h0, 0, 9'h0, 0, 0, 0));
      repeat (2) @(negedge clk);
      checkReset("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i]);
      end

      // Branch near the top of the address space, then walk across the wrap
      applyStimulus(mkVec(STALL_RUN, 1, 32'hFFFFFFF8, 32'h11111111, ctrlSw, 32'hFFFFFFF8, 32'h0,        32'h0,        0, ctrlSw, 2, 2, 0));
      applyStimulus(mkVec(STALL_RUN, 0, 32'h0,        32'h22222222, ctrlR,  32'hFFFFFFFC, 32'h22222222, 32'hFFFFFFFC, 1, ctrlR,  2, 2, 0));
      applyStimulus(mkVec(STALL_RUN, 0, 32'h0,        32'h33333333, ctrlLw, 32'h0,        32'h33333333, 32'h0,        1, ctrlLw, 2, 2, 0));

      // Long stall: 4-bit stall counter climbs from 2 and pins at 15
      for (int i = 0; i < 20; i++) begin
         applyStimulus(mkVec(STALL_HOLD, 0, 32'h0, 32'h44444444, ctrlR, 32'h0, 32'h33333333, 32'h0, 1, 9'h0,
                             (3 + i > 15) ? 15 : 3 + i, 2, 0));
      end

      // Illegal 100: datapath still follows each signal, error flag sticks
      applyStimulus(mkVec(3'b100,    0, 32'h0, 32'h55555555, ctrlLw, 32'h4, 32'h33333333, 32'h0, 1, ctrlLw, 15, 2, 1));
      applyStimulus(mkVec(STALL_RUN, 0, 32'h0, 32'h66666666, ctrlR,  32'h8, 32'h66666666, 32'h8, 1, ctrlR,  15, 2, 1));

      // Reset asserted mid-stall, checked before the next clock edge
      driveInputs(mkVec(STALL_HOLD, 0, 32'h0, 32'h77777777, ctrlLw, 32'h0, 32'h0, 32'h0, 0, 9'h0, 0, 0, 0));
      #2 rst_n = 1'b0;
      #1 checkReset("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(mkVec(STALL_RUN, 0, 32'h0, 32'h8C080004, ctrlLw, 32'h4, 32'h8C080004, 32'h4, 1, ctrlLw, 0, 0, 0));

      testsRun++;
      if (expQ.size() != 0) begin
         testsFailed++;
         $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", expQ.size());
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/fetch_stall_ctrl.md
Name: fetch_stall_ctrl

Overview:
- Consumes the stall requests from the hazard detection unit (pc_write, if_id_write, mux_sel) and the branch decision made in ID.
- Owns the PC register, the IF/ID pipeline register, and the ID/EX control-field register, including bubble insertion and branch flush.
- Keeps saturating stall/flush performance counters and a sticky protocol-error flag that catches inconsistent stall requests.

Parameters:
- PC_W, 32, width of the PC and the PC+4 field.
- INSTR_W, 32, width of the instruction word.
- CTRL_W, 9, width of the ID/EX control bundle (regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop[1:0]).
- RESET_PC, 0, PC value after reset.
- CNT_W, 16, width of each performance counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- pc_write  in  1  from hazard unit; 1 allows the PC to update
- if_id_write  in  1  from hazard unit; 1 allows IF/ID to load
- mux_sel  in  1  from hazard unit; 1 inserts a bubble into ID/EX control
- branch_taken  in  1  ID-stage branch resolved taken
- branch_target  in  PC_W  ID-stage branch target address
- instr_in  in  INSTR_W  instruction memory read data for the current pc
- id_ctrl_in  in  CTRL_W  control unit output for the instruction in ID
- pc  out  PC_W  current PC, drives the instruction memory address
- if_id_instr  out  INSTR_W  IF/ID instruction
- if_id_pc4  out  PC_W  IF/ID PC+4
- if_id_valid  out  1  IF/ID holds a real instruction (0 = flushed or reset bubble)
- id_ex_ctrl  out  CTRL_W  registered ID/EX control bundle
- stall_cnt  out  CNT_W  count of cycles with a bubble inserted
- flush_cnt  out  CNT_W  count of accepted taken branches
- protocol_err  out  1  sticky flag for inconsistent stall inputs

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: pc=RESET_PC; if_id_instr=0 (nop); if_id_pc4=0; if_id_valid=0; id_ex_ctrl=0; stall_cnt=0; flush_cnt=0; protocol_err=0.
- All outputs are registered. There is no combinational path from any input to any output.
- Accepted branch: branch_taken is honoured only when pc_write=1. When pc_write=0 the branch operands are not yet valid, so the branch is ignored; the hazard unit keeps the branch in ID until its operands are ready.
- PC update, in priority order:
  - pc_write=0: hold.
  - pc_write=1 and branch_taken=1: pc<=branch_target.
  - Otherwise: pc<=pc+4.
  - Arithmetic is modulo 2^PC_W (0xFFFFFFFC+4 wraps to 0).
- IF/ID update, in priority order:
  - if_id_write=0: hold all three fields.
  - if_id_write=1 and branch_taken=1: flush; instr<=0, pc4<=0, valid<=0.
  - Otherwise: instr<=instr_in, pc4<=pc+4, valid<=1.
- ID/EX control: loads every cycle and is never stalled.
  - mux_sel=1: id_ex_ctrl<=0 (bubble).
  - Otherwise: id_ex_ctrl<=id_ctrl_in.
- Latency: one cycle from a request to its register effect. A 1-cycle stall produces exactly one bubble in EX and holds pc and IF/ID for exactly one edge.
- stall_cnt: +1 on each edge where mux_sel=1; saturates at 2^CNT_W-1 with no wrap.
- flush_cnt: +1 on each edge where pc_write=1 and branch_taken=1; saturates at 2^CNT_W-1 with no wrap.
- Protocol check:
  - Legal input sets: {pc_write, if_id_write, mux_sel} = 110 or 001.
  - Any other combination sets protocol_err=1 on that edge; it clears only on reset.
  - The datapath still follows the per-signal rules above even when the combination is illegal.
- Simultaneous mux_sel=1 and branch_taken=1 (legal set 001): the branch is ignored and a bubble is inserted; flush_cnt is unchanged.
- Reset mid-stall: all state returns to reset values immediately. The first edge after rst_n rises behaves as a normal fetch from RESET_PC.

Decomposition:
- Shared package (pipeline_pkg):
  - CTRL_W.
  - Control-bundle bit-index constants.
  - NOP_INSTR = 0.
  - RESET_PC default.
  - Legal stall-encoding constants STALL_RUN=3'b110 and STALL_HOLD=3'b001.
- Sub-module sat_counter (width CNT_W; inc input; saturating), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset, then 3 run cycles (110), instr_in=0x8C080004/0x01094020/0x00000000 -> pc goes 0,4,8,12; if_id_pc4 goes 4,8,12; if_id_valid=1; id_ex_ctrl equals id_ctrl_in delayed 1 cycle; both counters stay 0.
- Load-use: one 001 cycle at pc=8 -> pc stays 8; if_id_instr holds 0x01094020; id_ex_ctrl=0 for one cycle; stall_cnt=1; protocol_err=0.
- Taken branch: 110 with branch_taken=1, branch_target=0x40, at pc=0x10 -> next pc=0x40, if_id_instr=0, if_id_valid=0, flush_cnt=1.
- Branch during stall: 001 with branch_taken=1 -> pc held, no flush, flush_cnt unchanged, id_ex_ctrl=0, stall_cnt+1.
- Wrap and saturation:
  - pc=0xFFFFFFFC with 110 -> pc=0x00000000.
  - With CNT_W=4, 20 stall cycles -> stall_cnt=15 and holds at 15.
- Illegal input 100, then 110 -> protocol_err=1 and stays 1; rst_n low mid-stall -> all outputs return to reset values asynchronously.
